// File: rtl/ldst_unit.sv
// Load/store unit: registers the effective address, runs a strobe/ready handshake
// with data memory, bounds stalls with a wait counter and reports via a done pulse.
module ldst_unit #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [DW-1:0] req_base,
    input  logic [AW-1:0] req_offset,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ld_data,
    output logic          done,
    output logic          ld_valid,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

    // Last wait-counter value before a stalled access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          done_q, done_d;
    logic          ld_valid_q, ld_valid_d;
    logic          err_q, err_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;

    // Upper base bits beyond the address width carry no meaning here.
    logic unused_base_bits;
    assign unused_base_bits = ^req_base;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        ld_data_d   = ld_data_q;
        done_d      = done_q;
        ld_valid_d  = ld_valid_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = ADDR;
                    we_d        = req_we;
                    mem_wdata_d = req_wdata;
                    mem_addr_d  = req_base[AW-1:0] + req_offset;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ADDR: begin
                state_d  = ACCESS;
                mem_re_d = !we_q;
                mem_we_d = we_q;
            end
            ACCESS: begin
                // A ready on the final allowed cycle still completes normally.
                if (mem_ready) begin
                    if (!we_q) ld_data_d = mem_rdata;
                    mem_re_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    err_d      = 1'b0;
                    ld_valid_d = !we_q;
                end else if (cnt_q < TO_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    if (!we_q) ld_data_d = '0;
                    mem_re_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    ld_valid_d = 1'b0;
                end
            end
            DONE: begin
                state_d     = IDLE;
                cnt_d       = '0;
                done_d      = 1'b0;
                ld_valid_d  = 1'b0;
                err_d       = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ld_data_q   <= '0;
            done_q      <= 1'b0;
            ld_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            ld_data_q   <= ld_data_d;
            done_q      <= done_d;
            ld_valid_q  <= ld_valid_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign ld_data   = ld_data_q;
    assign done      = done_q;
    assign ld_valid  = ld_valid_q;
    assign err       = err_q;

endmodule
